// File: rtl/sreg_ctrl_pkg.sv
// Shared types and helpers for the shift-register pipe controller.
package sreg_ctrl_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} sreg_ctrl_state_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sreg_pipe_ctrl_if.sv
// Upstream/downstream valid-ready handshake bundle for sreg_pipe_ctrl.
interface sreg_pipe_ctrl_if;

    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    // master is the producer/consumer environment; slave is the controller
    modport master (output in_valid, out_ready, input in_ready, out_valid);
    modport slave  (input in_valid, out_ready, output in_ready, out_valid);

endinterface

// File: rtl/sreg_valid_track.sv
// Per-stage valid bits: DEPTH-deep shift register with clock enable and synchronous clear.
module sreg_valid_track #(
    parameter int DEPTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             clr,
    input  logic             din,
    output logic [DEPTH-1:0] q
);

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   q <= '0;
                else if (clr) q <= '0;
                else if (ce)  q <= din;
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   q <= '0;
                else if (clr) q <= '0;
                else if (ce)  q <= {q[DEPTH-2:0], din};
            end
        end
    endgenerate

endmodule

// File: rtl/sreg_pipe_ctrl.sv
// Valid/ready flow controller for a CE-gated fixed-latency shift-register datapath.
// Optional build macro SREG_CTRL_IDLE_GATE_EN holds sreg_ce low while the pipe is empty.
module sreg_pipe_ctrl
    import sreg_ctrl_pkg::*;
#(
    parameter  int DEPTH = 18,
    localparam int CNT_W = occ_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    sreg_pipe_ctrl_if.slave   bus,
    output logic              sreg_ce,
    input  logic              drain,
    input  logic              flush,
    output logic              drain_done,
    output logic              busy,
    output logic [CNT_W-1:0]  occupancy
);

    sreg_ctrl_state_t state, next_state;
    logic [DEPTH-1:0] valid_q;
    logic             ce_raw;
    logic             accept;
    logic             xfer;

    assign ce_raw        = !valid_q[DEPTH-1] || bus.out_ready;
    assign bus.in_ready  = rst_n && ce_raw && (state == RUN) && !flush;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = valid_q[DEPTH-1];
    assign xfer          = bus.out_valid && bus.out_ready;
    assign busy          = (occupancy != '0) || (state != RUN);

`ifdef SREG_CTRL_IDLE_GATE_EN
    // An empty pipe only shifts zeros, so suppressing CE leaves valid/occupancy unchanged.
    assign sreg_ce = ce_raw && (accept || (occupancy != '0));
`else
    assign sreg_ce = ce_raw;
`endif

    sreg_valid_track #(.DEPTH(DEPTH)) u_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (sreg_ce),
        .clr   (flush),
        .din   (accept),
        .q     (valid_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 occupancy <= '0;
        else if (flush)             occupancy <= '0;
        else if (accept && !xfer)   occupancy <= occupancy + CNT_W'(1);
        else if (xfer && !accept)   occupancy <= occupancy - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        drain_done = 1'b0;
        case (state)
            RUN:   if (drain) next_state = DRAIN;
            DRAIN: if (flush || (occupancy == '0)) next_state = DONE;
            DONE: begin
                drain_done = 1'b1;
                next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

endmodule

// File: tb/tb_sreg_pipe_ctrl.sv
// Directed self-checking bench for sreg_pipe_ctrl at DEPTH 18, 8, 4 and 1.
module tb_sreg_pipe_ctrl;

    logic clk;
    logic rst_n;

    sreg_pipe_ctrl_if b18 ();
    sreg_pipe_ctrl_if b8 ();
    sreg_pipe_ctrl_if b4 ();
    sreg_pipe_ctrl_if b1 ();

    logic       ce18, dr18, fl18, dd18, bz18;
    logic [4:0] oc18;
    logic       ce8, dr8, fl8, dd8, bz8;
    logic [3:0] oc8;
    logic       ce4, dr4, fl4, dd4, bz4;
    logic [2:0] oc4;
    logic       ce1, dr1, fl1, dd1, bz1;
    logic [0:0] oc1;

    int n_vec = 0;
    int n_err = 0;

`ifdef SREG_CTRL_IDLE_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    sreg_pipe_ctrl #(.DEPTH(18)) u18 (
        .clk(clk), .rst_n(rst_n), .bus(b18.slave), .sreg_ce(ce18), .drain(dr18),
        .flush(fl18), .drain_done(dd18), .busy(bz18), .occupancy(oc18));
    sreg_pipe_ctrl #(.DEPTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(b8.slave), .sreg_ce(ce8), .drain(dr8),
        .flush(fl8), .drain_done(dd8), .busy(bz8), .occupancy(oc8));
    sreg_pipe_ctrl #(.DEPTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave), .sreg_ce(ce4), .drain(dr4),
        .flush(fl4), .drain_done(dd4), .busy(bz4), .occupancy(oc4));
    sreg_pipe_ctrl #(.DEPTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave), .sreg_ce(ce1), .drain(dr1),
        .flush(fl1), .drain_done(dd1), .busy(bz1), .occupancy(oc1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        b18.in_valid = 1'b1; b18.out_ready = 1'b0; dr18 = 1'b0; fl18 = 1'b0;
        b8.in_valid  = 1'b0; b8.out_ready  = 1'b0; dr8  = 1'b0; fl8  = 1'b0;
        b4.in_valid  = 1'b0; b4.out_ready  = 1'b0; dr4  = 1'b0; fl4  = 1'b0;
        b1.in_valid  = 1'b0; b1.out_ready  = 1'b0; dr1  = 1'b0; fl1  = 1'b0;

        // reset state
        #12;
        check_eq("rst_in_ready", int'(b18.in_ready), 0);
        check_eq("rst_out_valid", int'(b18.out_valid), 0);
        check_eq("rst_busy", int'(bz18), 0);
        check_eq("rst_occ", int'(oc18), 0);
        check_eq("rst_drain_done", int'(dd18), 0);
        cyc();
        rst_n = 1'b1;

        // DEPTH=18 streaming: latency 18, steady occupancy 18
        b18.in_valid = 1'b1; b18.out_ready = 1'b1;
        #2;
        check_eq("a_in_ready0", int'(b18.in_ready), 1);
        check_eq("a_ce0", int'(ce18), 1);
        for (int k = 0; k < 25; k++) begin
            cyc(); #2;
            check_eq("a_out_valid", int'(b18.out_valid), int'(k >= 17));
            check_eq("a_occ", int'(oc18), (k + 1 > 18) ? 18 : k + 1);
            check_eq("a_ce", int'(ce18), 1);
        end
        b18.in_valid = 1'b0;

        // DEPTH=4 fill to full with backpressure, then drain out
        b4.in_valid = 1'b1; b4.out_ready = 1'b0;
        repeat (4) cyc();
        b4.in_valid = 1'b0;
        #2;
        check_eq("b_occ_full", int'(oc4), 4);
        check_eq("b_in_ready_full", int'(b4.in_ready), 0);
        check_eq("b_ce_full", int'(ce4), 0);
        check_eq("b_out_valid_full", int'(b4.out_valid), 1);
        cyc(); #2;
        check_eq("b_occ_hold", int'(oc4), 4);
        check_eq("b_out_valid_hold", int'(b4.out_valid), 1);
        b4.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_eq("b_out_valid_xfer", int'(b4.out_valid), 1);
            cyc(); #2;
            check_eq("b_occ_xfer", int'(oc4), 3 - j);
        end
        check_eq("b_out_valid_empty", int'(b4.out_valid), 0);

        // DEPTH=8 drain with 3 items in flight
        b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        repeat (3) cyc();
        b8.in_valid = 1'b0; dr8 = 1'b1;
        #2;
        check_eq("c_occ_start", int'(oc8), 3);
        cyc();
        dr8 = 1'b0; b8.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #2;
            check_eq("c_out_valid", int'(b8.out_valid), int'(k >= 4 && k <= 6));
            check_eq("c_occ", int'(oc8), (k <= 4) ? 3 : (k == 5) ? 2 : (k == 6) ? 1 : 0);
            check_eq("c_drain_done", int'(dd8), int'(k == 8));
            check_eq("c_in_ready", int'(b8.in_ready), int'(k >= 9));
            check_eq("c_busy", int'(bz8), int'(k < 9));
            if (k == 9) b8.in_valid = 1'b0;
            else        cyc();
        end

        // DEPTH=8 flush with 5 items in flight
        b8.in_valid = 1'b1;
        repeat (5) cyc();
        fl8 = 1'b1;
        #2;
        check_eq("d_in_ready_flush", int'(b8.in_ready), 0);
        cyc();
        fl8 = 1'b0; b8.in_valid = 1'b0;
        #2;
        check_eq("d_occ_flushed", int'(oc8), 0);
        check_eq("d_out_valid_flushed", int'(b8.out_valid), 0);
        check_eq("d_busy_flushed", int'(bz8), 0);

        // flush together with drain
        b8.in_valid = 1'b1;
        repeat (5) cyc();
        b8.in_valid = 1'b0; fl8 = 1'b1; dr8 = 1'b1;
        cyc();
        fl8 = 1'b0; dr8 = 1'b0;
        #2;
        check_eq("e_occ", int'(oc8), 0);
        check_eq("e_busy_drain", int'(bz8), 1);
        check_eq("e_drain_done_1", int'(dd8), 0);
        cyc(); #2;
        check_eq("e_drain_done_2", int'(dd8), 1);
        cyc(); #2;
        check_eq("e_drain_done_3", int'(dd8), 0);
        check_eq("e_busy_end", int'(bz8), 0);
        check_eq("e_in_ready_end", int'(b8.in_ready), 1);

        // asynchronous reset while draining with occupancy 6
        b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        repeat (6) cyc();
        b8.in_valid = 1'b0;
        repeat (2) cyc();
        b8.out_ready = 1'b0; dr8 = 1'b1;
        cyc();
        dr8 = 1'b0;
        #2;
        check_eq("r_busy_pre", int'(bz8), 1);
        check_eq("r_occ_pre", int'(oc8), 6);
        check_eq("r_out_valid_pre", int'(b8.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check_eq("r_out_valid_async", int'(b8.out_valid), 0);
        check_eq("r_busy_async", int'(bz8), 0);
        check_eq("r_occ_async", int'(oc8), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            check_eq("r_drain_done_post", int'(dd8), 0);
            check_eq("r_in_ready_post", int'(b8.in_ready), 1);
            check_eq("r_busy_post", int'(bz8), 0);
            cyc();
        end

        // idle CE behaviour and single-item latency
        for (int k = 0; k < 10; k++) begin
            #2;
            check_eq("f_ce_idle", int'(ce8), GATED ? 0 : 1);
            cyc();
        end
        b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        #2;
        check_eq("f_ce_accept", int'(ce8), 1);
        check_eq("f_in_ready_accept", int'(b8.in_ready), 1);
        cyc();
        b8.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #2;
            check_eq("f_out_valid", int'(b8.out_valid), int'(k == 7));
            check_eq("f_ce", int'(ce8), GATED ? int'(k <= 7) : 1);
            cyc();
        end

        // DEPTH=1 single register
        b1.in_valid = 1'b1; b1.out_ready = 1'b0;
        #2;
        check_eq("g_in_ready0", int'(b1.in_ready), 1);
        cyc(); #2;
        check_eq("g_out_valid1", int'(b1.out_valid), 1);
        check_eq("g_occ1", int'(oc1), 1);
        check_eq("g_in_ready_full", int'(b1.in_ready), 0);
        b1.out_ready = 1'b1;
        #1;
        check_eq("g_in_ready_pass", int'(b1.in_ready), 1);
        cyc(); #2;
        check_eq("g_out_valid2", int'(b1.out_valid), 1);
        check_eq("g_occ2", int'(oc1), 1);
        b1.in_valid = 1'b0;
        cyc(); #2;
        check_eq("g_out_valid3", int'(b1.out_valid), 0);
        check_eq("g_occ3", int'(oc1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
